// File: rtl/spi_sar_adc_responder.sv
// SPI responder model of a SAR ADC: samples analog_volts on CS_N fall and resolves one bit per SCLK fall, MSB first.
// Optional parity bit after the LSB when SAR_ADC_PARITY_EN is defined; all SPI pins are oversampled in the clk domain.
module spi_sar_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int LEAD_BITS   = 2,
    parameter int FRAME_LEN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] analog_volts,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              busy,
    output logic              conv_done,
    output logic [DATA_W-1:0] last_result,
    output logic              powered_down
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CONV_LO   = CNT_W'(LEAD_BITS);
    localparam logic [CNT_W-1:0] PAR_POS   = CNT_W'(LEAD_BITS + DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LEAD, CONVERT, TAIL, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_q, cs_q;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    // cs_n synchronizer resets high so reset release never looks like a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] hold, hold_nxt, acc, acc_nxt, mask, mask_nxt, trial;
    logic [DATA_W-1:0] last_result_nxt;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_nxt, pos;
    logic pd_req, pd_req_nxt, miso_nxt, oe_nxt, busy_nxt, done_nxt, pd_nxt, bit_v;

    always_comb begin
        state_nxt       = state;
        hold_nxt        = hold;
        acc_nxt         = acc;
        mask_nxt        = mask;
        edge_cnt_nxt    = edge_cnt;
        pd_req_nxt      = pd_req;
        miso_nxt        = spi_miso;
        oe_nxt          = spi_miso_oe;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        last_result_nxt = last_result;
        pd_nxt          = powered_down;
        bit_v           = 1'b0;
        trial           = acc | mask;
        pos             = edge_cnt + CNT_W'(1);

        if (state == IDLE) begin
            if (cs_fall) begin
                hold_nxt     = analog_volts;
                acc_nxt      = '0;
                mask_nxt     = MSB_MASK;
                edge_cnt_nxt = '0;
                pd_req_nxt   = 1'b0;
                busy_nxt     = 1'b1;
                miso_nxt     = 1'b0;
                oe_nxt       = ~powered_down;
                state_nxt    = LEAD;
            end
        end else if (cs_s) begin
            // cs_n high outranks any same-cycle SCLK edge: completion only from DONE
            if (state == DONE) begin
                last_result_nxt = acc;
                done_nxt        = 1'b1;
                pd_nxt          = pd_req;
            end
            busy_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            miso_nxt  = 1'b0;
            state_nxt = IDLE;
        end else if (state != DONE) begin
            if (sclk_rise && state == LEAD && edge_cnt == '0)
                pd_req_nxt = mosi_s;
            if (sclk_fall) begin
                edge_cnt_nxt = pos;
                if (pos >= CONV_LO && pos < PAR_POS) begin
                    if (hold >= trial) begin
                        acc_nxt = trial;
                        bit_v   = 1'b1;
                    end
                    mask_nxt = mask >> 1;
                end else if (pos == PAR_POS) begin
`ifdef SAR_ADC_PARITY_EN
                    bit_v = ^acc;
`else
                    bit_v = 1'b0;
`endif
                end
                miso_nxt = bit_v & ~powered_down;
                if (edge_cnt == LAST_EDGE)
                    state_nxt = DONE;
                else if (pos < CONV_LO)
                    state_nxt = LEAD;
                else if (pos < PAR_POS)
                    state_nxt = CONVERT;
                else
                    state_nxt = TAIL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            acc          <= '0;
            mask         <= '0;
            edge_cnt     <= '0;
            pd_req       <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            busy         <= 1'b0;
            conv_done    <= 1'b0;
            last_result  <= '0;
            powered_down <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold         <= hold_nxt;
            acc          <= acc_nxt;
            mask         <= mask_nxt;
            edge_cnt     <= edge_cnt_nxt;
            pd_req       <= pd_req_nxt;
            spi_miso     <= miso_nxt;
            spi_miso_oe  <= oe_nxt;
            busy         <= busy_nxt;
            conv_done    <= done_nxt;
            last_result  <= last_result_nxt;
            powered_down <= pd_nxt;
        end
    end
endmodule
